game_ctrl: RTL
==============

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter H_VIS, default 640, visible pixels per line.
REQ-002 Parameter V_VIS, default 480, visible lines per frame.
REQ-003 Parameter LIVES, default 3, lives per game (1..7).
REQ-004 Parameter SCORE_MS, default 1000, survival ms per score point.
REQ-005 Parameter DEAD_MS, default 1000, ms spent in DEAD before respawn.
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 clk_1ms  input  1  1 kHz tick from the clock divider, sampled on clk.
REQ-009 button, button1  input  1 each  raw player buttons, asynchronous to clk.
REQ-010 x, y  input  16 each  current VGA pixel coordinates.
REQ-011 player_on, enemy_on  input  1 each  sprite-coverage flags for the current pixel.
REQ-012 game_state  output  2  0=IDLE, 1=PLAY, 2=DEAD, 3=OVER.
REQ-013 p1_score  output  4  current score.
REQ-014 lives  output  3  remaining lives.
REQ-015 player_dead  output  1  high while in DEAD.
REQ-016 enemy_respawn  output  1  one-clk pulse telling the enemy block to reload its start position.
REQ-017 led  output  1  high while in OVER.

Function
REQ-018 button and button1 SHALL each pass through a 2-flop synchronizer; a press is the rising edge of the synchronized value; btn_any is a press on either button.
REQ-019 The ms tick is the rising edge of the registered clk_1ms, one clk wide.
REQ-020 frame_end is a one-clk pulse on the rising edge of (y == V_VIS).
REQ-021 hit flag is set in any clk where player_on && enemy_on && x < H_VIS && y < V_VIS while in PLAY; it is cleared on every frame_end and on every state change.
REQ-022 IDLE: p1_score=0, lives=LIVES, counters cleared; btn_any -> PLAY with an enemy_respawn pulse.
REQ-023 PLAY: ms counter counts ticks 0..SCORE_MS-1; on wrap, p1_score increments, saturating at 15.
REQ-024 PLAY: on frame_end with hit=1, lives decrements; -> DEAD if the pre-decrement lives > 1, else -> OVER with lives=0.
REQ-025 If a score wrap coincides with a hit-frame_end, the transition wins and that score increment is discarded.
REQ-026 DEAD: ms counter restarts at 0 on entry; after DEAD_MS ticks -> PLAY with an enemy_respawn pulse in the transition clk; the score ms counter restarts at 0.
REQ-027 OVER: p1_score and lives hold; btn_any -> IDLE; presses in any state other than IDLE and OVER are ignored.
REQ-028 All outputs are registered; game_state changes one clk after the triggering event.

Reset
REQ-029 Asserting reset at any time, including mid-DEAD, SHALL force: game_state=IDLE, p1_score=0, lives=LIVES, player_dead=0, enemy_respawn=0, led=0, hit=0, all counters and synchronizer flops 0.

Structure
REQ-030 A shared package holds the game_state_t enum (IDLE, PLAY, DEAD, OVER) and the default screen/timing constants for reuse by render and enemy.
REQ-031 One sub-module, btn_sync (2-flop synchronizer plus rising-edge detect), is instantiated for button and button1.

Verification
REQ-032 Reset, press button -> game_state 0->1 one clk after the edge, one enemy_respawn pulse.
REQ-033 PLAY with no overlap for 3000 ms ticks (SCORE_MS=1000) -> p1_score=3; with 20000 ticks -> p1_score saturates at 15.
REQ-034 player_on=enemy_on=1 at x=100, y=100, then frame_end -> lives 3->2, state DEAD, player_dead=1; after 1000 ticks -> PLAY plus enemy_respawn.
REQ-035 Overlap only at x=700 (blanking) -> no hit, lives unchanged.
REQ-036 Three hit frames -> state OVER, lives=0, led=1; button1 press -> IDLE, score 0, lives 3.
REQ-037 Reset asserted at DEAD tick 500 -> all outputs at reset values on the same clk edge; subsequent press starts a fresh game.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared game-controller types and default screen/timing constants.
// Render and enemy blocks import this too, so the defaults live here.
package game_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DEAD = 2'd2,
      OVER = 2'd3
   } game_state_t;

   localparam int H_VIS_DEF    = 640;
   localparam int V_VIS_DEF    = 480;
   localparam int H_TOTAL_DEF  = 800;
   localparam int V_TOTAL_DEF  = 525;
   localparam int LIVES_DEF    = 3;
   localparam int SCORE_MS_DEF = 1000;
   localparam int DEAD_MS_DEF  = 1000;

   localparam logic [3:0] SCORE_MAX = 4'd15;

   // Score increment that sticks at the top of the 4-bit display range.
   function automatic logic [3:0] score_sat_inc(input logic [3:0] v);
      return (v == SCORE_MAX) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Signal bundle between the game controller and the rest of the VGA game.
// master = controller side, slave = surrounding logic (or a bench).
interface game_ctrl_if;
   logic        clk_1ms;
   logic        button;
   logic        button1;
   logic [15:0] x;
   logic [15:0] y;
   logic        player_on;
   logic        enemy_on;
   logic [1:0]  game_state;
   logic [3:0]  p1_score;
   logic [2:0]  lives;
   logic        player_dead;
   logic        enemy_respawn;
   logic        led;

   modport master (
      input  clk_1ms, button, button1, x, y, player_on, enemy_on,
      output game_state, p1_score, lives, player_dead, enemy_respawn, led
   );

   modport slave (
      output clk_1ms, button, button1, x, y, player_on, enemy_on,
      input  game_state, p1_score, lives, player_dead, enemy_respawn, led
   );
endinterface

// File: rtl/game_ctrl_btn_sync.sv
// Raw push-button to one-clk press pulse: 2-flop synchronizer, then
// rising-edge detect on the synchronized level.
module btn_sync (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic press_o
);
   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchronizer chain plus one history flop for the edge detector.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign press_o = sync_q & ~prev_q;
endmodule

// File: rtl/game_ctrl.sv
// Game controller: IDLE/PLAY/DEAD/OVER flow, survival score, lives and
// collision detection on visible pixels, evaluated once per frame.
module game_ctrl
   import game_ctrl_pkg::*;
#(
   parameter int H_VIS    = H_VIS_DEF,
   parameter int V_VIS    = V_VIS_DEF,
   parameter int LIVES    = LIVES_DEF,
   parameter int SCORE_MS = SCORE_MS_DEF,
   parameter int DEAD_MS  = DEAD_MS_DEF
) (
   input  logic clk,
   input  logic reset,
   game_ctrl_if.master bus
);
   localparam int             CNT_W      = 16;
   localparam logic [CNT_W-1:0] SCORE_LAST = CNT_W'(SCORE_MS - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_MS - 1);
   localparam logic [2:0]     LIVES_INIT = 3'(LIVES);

   // ---------------- button presses ----------------
   logic [1:0] btn_raw;
   logic [1:0] btn_press;
   logic       btn_any;

   assign btn_raw = {bus.button1, bus.button};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         btn_sync u_btn_sync (
            .clk     (clk),
            .reset   (reset),
            .btn_i   (btn_raw[gi]),
            .press_o (btn_press[gi])
         );
      end
   endgenerate

   assign btn_any = |btn_press;

   // ---------------- ms tick and frame_end ----------------
   // Both event sources get the same register-then-edge treatment so
   // a tick and a frame_end driven in the same clk land together.
   logic ms_r_q, ms_prev_q;
   logic yv_q, yv_prev_q;
   logic ms_tick;
   logic frame_end;

   // Register the 1 kHz level and the end-of-visible-frame condition.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ms_r_q    <= 1'b0;
         ms_prev_q <= 1'b0;
         yv_q      <= 1'b0;
         yv_prev_q <= 1'b0;
      end else begin
         ms_r_q    <= bus.clk_1ms;
         ms_prev_q <= ms_r_q;
         yv_q      <= (bus.y == 16'(V_VIS));
         yv_prev_q <= yv_q;
      end
   end

   assign ms_tick   = ms_r_q & ~ms_prev_q;
   assign frame_end = yv_q & ~yv_prev_q;

   // Sprite overlap only counts inside the visible window.
   logic overlap_vis;
   assign overlap_vis = bus.player_on && bus.enemy_on &&
                        (bus.x < 16'(H_VIS)) && (bus.y < 16'(V_VIS));

   // ---------------- game FSM ----------------
   game_state_t      state_q, state_d;
   logic [3:0]       score_q, score_d;
   logic [2:0]       lives_q, lives_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_q, hit_d;
   logic             respawn_q, respawn_d;
   logic             dead_q, led_q;

   // State and game registers; status flags decode the next state so
   // they line up with game_state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         score_q   <= '0;
         lives_q   <= LIVES_INIT;
         cnt_q     <= '0;
         hit_q     <= 1'b0;
         respawn_q <= 1'b0;
         dead_q    <= 1'b0;
         led_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         score_q   <= score_d;
         lives_q   <= lives_d;
         cnt_q     <= cnt_d;
         hit_q     <= hit_d;
         respawn_q <= respawn_d;
         dead_q    <= (state_d == DEAD);
         led_q     <= (state_d == OVER);
      end
   end

   // Next-state logic; a hit frame_end takes priority over a score wrap
   // in the same clk, dropping that increment.
   always_comb begin
      state_d   = state_q;
      score_d   = score_q;
      lives_d   = lives_q;
      cnt_d     = cnt_q;
      respawn_d = 1'b0;
      hit_d     = hit_q;

      if (frame_end)
         hit_d = 1'b0;
      else if ((state_q == PLAY) && overlap_vis)
         hit_d = 1'b1;

      case (state_q)
         IDLE: begin
            score_d = '0;
            lives_d = LIVES_INIT;
            cnt_d   = '0;
            if (btn_any) begin
               state_d   = PLAY;
               respawn_d = 1'b1;
            end
         end
         PLAY: begin
            if (frame_end && hit_q) begin
               cnt_d = '0;
               if (lives_q > 3'd1) begin
                  lives_d = lives_q - 3'd1;
                  state_d = DEAD;
               end else begin
                  lives_d = '0;
                  state_d = OVER;
               end
            end else if (ms_tick) begin
               if (cnt_q == SCORE_LAST) begin
                  cnt_d   = '0;
                  score_d = score_sat_inc(score_q);
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DEAD: begin
            if (ms_tick) begin
               if (cnt_q == DEAD_LAST) begin
                  cnt_d     = '0;
                  state_d   = PLAY;
                  respawn_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         OVER: begin
            if (btn_any) begin
               state_d = IDLE;
               score_d = '0;
               lives_d = LIVES_INIT;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q)
         hit_d = 1'b0;
   end

   assign bus.game_state    = state_q;
   assign bus.p1_score      = score_q;
   assign bus.lives         = lives_q;
   assign bus.player_dead   = dead_q;
   assign bus.enemy_respawn = respawn_q;
   assign bus.led           = led_q;
endmodule
